// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the per-core caches, the arbiter and the RAM model.
//   Core side : iREN/iaddr (instruction), dREN/dWEN/daddr/dstore (data) requests in;
//               iwait/dwait/iload/dload/merr back to the cores.
//   RAM side  : ramREN/ramWEN/ramaddr/ramstore out to RAM; ramload/ramstate back.
// Modports:
//   slave  - arbiter view (consumes requests and RAM status, drives grants/RAM controls)
//   master - environment view (caches + RAM model)
interface mem_arbiter_rr_if #(
    parameter int unsigned CPUS   = 2,
    parameter int unsigned WORD_W = 32
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS*WORD_W-1:0] iaddr;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*WORD_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS*WORD_W-1:0] dload;
    logic [CPUS-1:0]        merr;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of CPUS cores (one instruction + one data port each) onto one RAM port.
// Data requests have strict priority over instruction requests; within a class the first
// active core at or after that class's pointer wins. A grant is held until RAM reports
// ACCESS/ERROR, the request drops (abort), or the grant has waited TIMEOUT cycles.
// Ports:
//   CLK - rising-edge clock
//   RST - asynchronous active-high reset
//   bus - mem_arbiter_rr_if.slave: core requests/responses and RAM control/status
module mem_arbiter_rr #(
    parameter int unsigned CPUS    = 2,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             CLK,
    input logic             RST,
    mem_arbiter_rr_if.slave bus
);
    localparam int unsigned PtrW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    typedef enum logic {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] gnt_core_q, gnt_core_d;
    logic            gnt_is_d_q, gnt_is_d_d;
    logic            gnt_is_w_q, gnt_is_w_d;
    logic [PtrW-1:0] d_ptr_q, d_ptr_d;
    logic [PtrW-1:0] i_ptr_q, i_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [CPUS-1:0]   d_act;
    logic [PtrW:0]     d_pick, i_pick;  // {found, core}
    logic              pick_wen;
    logic              g_iren, g_dact, g_active;
    logic [WORD_W-1:0] g_iaddr, g_daddr, g_dstore;
    logic              done, err;
    logic              ram_ren, ram_wen;
    logic [WORD_W-1:0] ram_addr, ram_store;
    logic [CPUS-1:0]   iwait, dwait, merr;

    // First active core at or after ptr, wrapping. The second pass overrides the wrapped
    // candidate whenever some active core sits at or above ptr.
    function automatic logic [PtrW:0] pick_first(input logic [CPUS-1:0] act,
                                                 input logic [PtrW-1:0] ptr);
        logic [PtrW:0] res;
        res = '0;
        for (int c = int'(CPUS) - 1; c >= 0; c--) begin
            if (act[c]) res = {1'b1, PtrW'(c)};
        end
        for (int c = int'(CPUS) - 1; c >= 0; c--) begin
            if (act[c] && c >= int'(ptr)) res = {1'b1, PtrW'(c)};
        end
        return res;
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] v);
        if (32'(v) == CPUS - 1) return '0;
        return v + PtrW'(1);
    endfunction

    assign d_act  = bus.dREN | bus.dWEN;
    assign d_pick = pick_first(d_act, d_ptr_q);
    assign i_pick = pick_first(bus.iREN, i_ptr_q);

    // Per-core muxes for the granted core and the write flag of the data pick.
    always_comb begin
        g_iren   = 1'b0;
        g_dact   = 1'b0;
        g_iaddr  = '0;
        g_daddr  = '0;
        g_dstore = '0;
        pick_wen = 1'b0;
        for (int c = 0; c < int'(CPUS); c++) begin
            if (gnt_core_q == PtrW'(c)) begin
                g_iren   = bus.iREN[c];
                g_dact   = d_act[c];
                g_iaddr  = bus.iaddr[c*WORD_W +: WORD_W];
                g_daddr  = bus.daddr[c*WORD_W +: WORD_W];
                g_dstore = bus.dstore[c*WORD_W +: WORD_W];
            end
            if (d_pick[PtrW-1:0] == PtrW'(c)) pick_wen = bus.dWEN[c];
        end
    end

    assign g_active = gnt_is_d_q ? g_dact : g_iren;

    always_comb begin
        state_d    = state_q;
        gnt_core_d = gnt_core_q;
        gnt_is_d_d = gnt_is_d_q;
        gnt_is_w_d = gnt_is_w_q;
        d_ptr_d    = d_ptr_q;
        i_ptr_d    = i_ptr_q;
        cnt_d      = cnt_q;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (d_pick[PtrW]) begin
                    state_d    = StGrant;
                    gnt_core_d = d_pick[PtrW-1:0];
                    gnt_is_d_d = 1'b1;
                    gnt_is_w_d = pick_wen;
                end else if (i_pick[PtrW]) begin
                    state_d    = StGrant;
                    gnt_core_d = i_pick[PtrW-1:0];
                    gnt_is_d_d = 1'b0;
                    gnt_is_w_d = 1'b0;
                end
            end
            StGrant: begin
                ram_addr  = gnt_is_d_q ? g_daddr : g_iaddr;
                ram_store = gnt_is_d_q ? g_dstore : '0;
                if (!g_active) begin
                    // Requester withdrew: drop the RAM enables, keep pointers.
                    state_d = StIdle;
                end else begin
                    ram_wen = gnt_is_d_q && gnt_is_w_q;
                    ram_ren = !(gnt_is_d_q && gnt_is_w_q);
                    if (bus.ramstate == RamAccess) begin
                        done = 1'b1;
                    end else if (bus.ramstate == RamError || cnt_q == CntMax) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end
                    if (done) begin
                        state_d = StIdle;
                        if (gnt_is_d_q) d_ptr_d = ptr_inc(gnt_core_q);
                        else            i_ptr_d = ptr_inc(gnt_core_q);
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Active requests wait unless they are the grant completing this cycle.
    always_comb begin
        iwait = bus.iREN;
        dwait = d_act;
        merr  = '0;
        for (int c = 0; c < int'(CPUS); c++) begin
            if (done && gnt_core_q == PtrW'(c)) begin
                if (gnt_is_d_q) dwait[c] = 1'b0;
                else            iwait[c] = 1'b0;
                merr[c] = err;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            gnt_core_q <= '0;
            gnt_is_d_q <= 1'b0;
            gnt_is_w_q <= 1'b0;
            d_ptr_q    <= '0;
            i_ptr_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_core_q <= gnt_core_d;
            gnt_is_d_q <= gnt_is_d_d;
            gnt_is_w_q <= gnt_is_w_d;
            d_ptr_q    <= d_ptr_d;
            i_ptr_q    <= i_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.iwait    = iwait;
    assign bus.dwait    = dwait;
    assign bus.merr     = merr;
    assign bus.iload    = {CPUS{bus.ramload}};
    assign bus.dload    = {CPUS{bus.ramload}};
    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised successor to the single-core memory controller.
- Arbitrates CPUS cores, each with one instruction port and one data port, onto a single RAM port.
- A registered grant FSM holds the granted requester until RAM completes.
- Fairness: data requests have strict priority over instruction requests; round-robin among cores within each class. Adds timeout and error reporting.
- Sits between the per-core caches and the RAM model.

Parameters:
CPUS, 2, number of cores (1..8)
WORD_W, 32, address/data width
TIMEOUT, 255, max cycles a grant waits for RAM completion before abort (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
iREN  in  CPUS  instruction read request per core
iaddr  in  CPUS*WORD_W  instruction address, core c at bits [c*WORD_W +: WORD_W]
dREN  in  CPUS  data read request per core
dWEN  in  CPUS  data write request per core (dWEN wins over dREN of same core)
daddr  in  CPUS*WORD_W  data address per core
dstore  in  CPUS*WORD_W  data write value per core
iwait  out  CPUS  1 = instruction access not yet done
dwait  out  CPUS  1 = data access not yet done
iload  out  CPUS*WORD_W  instruction read data (ramload broadcast)
dload  out  CPUS*WORD_W  data read data (ramload broadcast)
merr  out  CPUS  per-core error flag, valid only in the completion cycle
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS (done), 3=ERROR

Behaviour:
- Requesters: data slot of core c (active when dREN[c]|dWEN[c]); instruction slot of core c (active when iREN[c]).
- FSM states: IDLE, GRANT.
- IDLE:
  - If any data slot is active, pick the first active core at or after d_ptr (modulo CPUS).
  - Else, if any instruction slot is active, pick the first at or after i_ptr.
  - Register the selection (gnt_core, gnt_is_d, gnt_is_w) and move to GRANT. Clear timeout counter.
  - RAM enables are 0 in IDLE.
- GRANT:
  - ramaddr/ramstore come from the granted port.
  - Data grant: ramWEN=gnt_is_w, ramREN=!gnt_is_w. Instruction grant: ramREN=1, ramWEN=0.
  - gnt_is_w is sampled at grant; later toggling of dWEN is ignored.
- Completion (combinational, in GRANT):
  - ramstate==ACCESS: granted wait=0 this cycle, merr=0.
  - ramstate==ERROR, or counter==TIMEOUT: granted wait=0 this cycle, merr[gnt_core]=1.
  - Next state is IDLE. The pointer of the served class advances to gnt_core+1 mod CPUS; the other pointer is unchanged.
- Counter increments each GRANT cycle without completion. It saturates; it does not wrap.
- Abort: if the granted request drops before completion, RAM enables deassert that cycle, FSM returns to IDLE, no merr, pointers unchanged.
- wait outputs: any active request not completing this cycle sees wait=1, whether pending or granted. Inactive ports see wait=0.
- Latency: a request seen in IDLE at cycle N drives the RAM from cycle N+1. Minimum turnaround is 2 cycles (ACCESS in N+1). After completion there is one IDLE cycle before the next grant.
- Same-core simultaneous data and instruction requests: data is served first.
- CPUS=1: pointers are constant 0.
- Reset (any time, including mid-GRANT): immediately state=IDLE, d_ptr=i_ptr=0, counter=0, ramREN=ramWEN=0, ramaddr=ramstore=0, merr=0. Wait outputs follow the combinational rule (1 for active requests). iload/dload are always ramload.

Test Plan:
- CPUS=2, single dREN[0], daddr0=0x40, ramstate ACCESS on 2nd grant cycle, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 from cycle 1; dwait[0]=0 in cycle 2; dload[0]=0xDEADBEEF; FSM back in IDLE.
- dWEN[0] and dWEN[1] held continuously, each access completes in 1 cycle -> grants alternate core0, core1, core0 with an IDLE gap between each; ramstore tracks the granted core's dstore.
- iREN[0] and dREN[1] asserted together -> core1 data served first, then core0 instruction; iwait[0]=1 throughout the data grant.
- Granted read with ramstate held BUSY, TIMEOUT=4 -> abort on the 5th GRANT cycle with dwait=0 and merr=1 for that core; the next request is then granted normally.
- ramstate=ERROR during a grant of iREN[1] -> iwait[1]=0 and merr[1]=1 for exactly one cycle; i_ptr=0 afterwards.
- RST pulsed mid-GRANT of a write -> ramWEN=0 the same cycle (asynchronous); after release the first grant goes to core 0 (pointers reset).
